// File: rtl/bit_distance_unit_if.sv
// Beat and result bundle for the bit-serial distance unit.
// The sender drives beats through master; the distance unit connects through slave.
interface bit_distance_unit_if #(
    parameter int B  = 32,
    parameter int BW = $clog2(B + 1)
);
    logic          valid;
    logic          q_bit;
    logic          r_bit;
    logic [1:0]    code;
    logic [BW-1:0] b;
    logic [B-1:0]  threshold;
    logic          terminate;
    logic          done;
    logic [B-1:0]  partial_distance_output;
    logic [B-1:0]  ref_coor_x;
    logic [B-1:0]  ref_coor_y;
    logic [B-1:0]  ref_coor_z;
    logic [B-1:0]  debug;

    modport master (
        output valid, q_bit, r_bit, code, b, threshold,
        input  terminate, done, partial_distance_output,
        input  ref_coor_x, ref_coor_y, ref_coor_z, debug
    );

    modport slave (
        input  valid, q_bit, r_bit, code, b, threshold,
        output terminate, done, partial_distance_output,
        output ref_coor_x, ref_coor_y, ref_coor_z, debug
    );
endinterface

// File: rtl/bit_distance_unit.sv
// Bit-serial squared-distance lower bound with early reject, for the KNN datapath.
// Each accepted beat refines one dimension; all outputs are registered post-update values.
module bit_distance_unit #(
    parameter int B = 32
) (
    input  logic              clk,
    input  logic              rst,
    bit_distance_unit_if.slave bus
);
    localparam int BW = $clog2(B + 1);
    localparam int DW = B + 2;
    localparam int SW = 2 * B + 2;

    // Lower bound on d^2 given the difference of the first bd bits; exact once bd == B.
    function automatic logic [B-1:0] bound_f(input logic [DW-1:0] d, input logic [BW-1:0] bd);
        logic [DW-1:0]    mag;
        logic [DW-1:0]    m;
        logic [BW-1:0]    shamt;
        logic [SW-1:0]    sh;
        logic [2*B-1:0]   sq;
        logic [B-1:0]     res;
        mag = d[DW-1] ? (~d + DW'(1)) : d;
        if (bd == BW'(B)) begin
            m     = mag;
            shamt = '0;
        end else begin
            m     = (mag == '0) ? '0 : (mag - DW'(1));
            shamt = BW'(B) - bd;
        end
        sh = SW'(m) << shamt;
        sq = (2 * B)'(sh[B-1:0]) * (2 * B)'(sh[B-1:0]);
        if (bd == '0)
            res = '0;
        else if ((|sh[SW-1:B]) || (|sq[2*B-1:B]))
            res = '1;
        else
            res = sq[B-1:0];
        return res;
    endfunction

    logic            r_terminate;
    logic            r_done;
    logic [B-1:0]    r_partial;
    logic [B-1:0]    r_debug;

    logic            w_in_range;
    logic            w_restart;
    logic            w_accept;
    logic [DW-1:0]   w_diff;
    logic [2:0][B-1:0] w_bound;
    logic [2:0][B-1:0] w_ref;
    logic [B+1:0]    w_sum;
    logic [B-1:0]    w_partial_next;
    logic [B-1:0]    w_debug_next;
    logic            w_term_next;
    logic            w_done_next;

    assign w_in_range = bus.valid && (bus.code != 2'b00) && (bus.b != '0) && (bus.b <= BW'(B));
    assign w_restart  = w_in_range && (bus.code == 2'b01) && (bus.b == BW'(1));
    assign w_accept   = w_in_range && (w_restart || !(r_terminate || r_done));

    assign w_diff = (bus.q_bit && !bus.r_bit) ? DW'(1) :
                    (!bus.q_bit && bus.r_bit) ? '1 : '0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dim
        logic [DW-1:0] r_delta;
        logic [B-1:0]  r_ref;
        logic [BW-1:0] r_bd;
        logic          w_sel;
        logic [DW-1:0] w_delta_base;
        logic [B-1:0]  w_ref_base;
        logic [BW-1:0] w_bd_base;
        logic [DW-1:0] w_delta_next;
        logic [B-1:0]  w_ref_next;
        logic [BW-1:0] w_bd_next;

        assign w_sel        = w_accept && (bus.code == 2'(gi + 1));
        // A restart clears every dimension before the selected one absorbs its bit.
        assign w_delta_base = w_restart ? '0 : r_delta;
        assign w_ref_base   = w_restart ? '0 : r_ref;
        assign w_bd_base    = w_restart ? '0 : r_bd;
        assign w_delta_next = w_sel ? ((w_delta_base << 1) + w_diff) : w_delta_base;
        assign w_ref_next   = w_sel ? {w_ref_base[B-2:0], bus.r_bit} : w_ref_base;
        assign w_bd_next    = w_sel ? bus.b : w_bd_base;

        assign w_bound[gi] = bound_f(w_delta_next, w_bd_next);
        assign w_ref[gi]   = r_ref;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_delta <= '0;
                r_ref   <= '0;
                r_bd    <= '0;
            end else if (w_accept) begin
                r_delta <= w_delta_next;
                r_ref   <= w_ref_next;
                r_bd    <= w_bd_next;
            end
        end
    end

    assign w_sum = (B + 2)'(w_bound[0]) + (B + 2)'(w_bound[1]) + (B + 2)'(w_bound[2]);
    assign w_partial_next = (|w_sum[B+1:B]) ? '1 : w_sum[B-1:0];

    always_comb begin
        w_debug_next = w_bound[0];
        case (bus.code)
            2'b10:   w_debug_next = w_bound[1];
            2'b11:   w_debug_next = w_bound[2];
            default: w_debug_next = w_bound[0];
        endcase
    end

    assign w_term_next = (w_partial_next >= bus.threshold);
    assign w_done_next = (bus.code == 2'b11) && (bus.b == BW'(B)) && !w_term_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_terminate <= 1'b0;
            r_done      <= 1'b0;
            r_partial   <= '0;
            r_debug     <= '0;
        end else if (w_accept) begin
            r_terminate <= w_term_next;
            r_done      <= w_done_next;
            r_partial   <= w_partial_next;
            r_debug     <= w_debug_next;
        end
    end

    assign bus.terminate               = r_terminate;
    assign bus.done                    = r_done;
    assign bus.partial_distance_output = r_partial;
    assign bus.debug                   = r_debug;
    assign bus.ref_coor_x              = w_ref[0];
    assign bus.ref_coor_y              = w_ref[1];
    assign bus.ref_coor_z              = w_ref[2];
endmodule

// File: tb/tb_bit_distance_unit.sv
// Directed and randomized streams for bit_distance_unit, compared against an
// integer-arithmetic model of prefix values, bounds and flags.
module tb_bit_distance_unit;
    localparam int B  = 32;
    localparam int BW = $clog2(B + 1);
    localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bit_distance_unit_if #(.B(B)) bus ();
    bit_distance_unit #(.B(B)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Model: prefix values of query/reference per dimension, last bit index, flags.
    longint          qp [3];
    longint          rp [3];
    int              bdm [3];
    bit              m_term, m_done;
    longint unsigned m_partial, m_debug;

    logic [31:0] thr;
    logic [31:0] qs [3];
    logic [31:0] rs [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned lb(input longint d, input int n);
        longint unsigned a, m, sh;
        if (n == 0) return 0;
        a = (d < 0) ? longint'(-d) : longint'(d);
        if (n == B) m = a;
        else m = (a > 0) ? a - 1 : 0;
        sh = m * (64'd1 << (B - n));
        if (sh > MAXV) return MAXV;
        if (sh * sh > MAXV) return MAXV;
        return sh * sh;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            qp[d] = 0; rp[d] = 0; bdm[d] = 0;
        end
        m_term = 0; m_done = 0; m_partial = 0; m_debug = 0;
    endtask

    task automatic model_step(input bit v, input int c, input int bi, input bit q, input bit r);
        longint unsigned l [3];
        longint unsigned s;
        int d;
        if (!(v && c != 0 && bi >= 1 && bi <= B)) return;
        if (!(c == 1 && bi == 1) && (m_term || m_done)) return;
        if (c == 1 && bi == 1) model_reset();
        d = c - 1;
        qp[d] = 2 * qp[d] + longint'(q);
        rp[d] = 2 * rp[d] + longint'(r);
        bdm[d] = bi;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            l[k] = lb(qp[k] - rp[k], bdm[k]);
            s += l[k];
        end
        m_partial = (s > MAXV) ? MAXV : s;
        m_debug   = l[d];
        m_term    = (m_partial >= longint'(thr));
        m_done    = (c == 3) && (bi == B) && !m_term;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".terminate"}, 64'(bus.terminate), 64'(m_term));
        chk({ctx, ".done"},      64'(bus.done),      64'(m_done));
        chk({ctx, ".partial"},   64'(bus.partial_distance_output), m_partial);
        chk({ctx, ".debug"},     64'(bus.debug),     m_debug);
        chk({ctx, ".ref_x"},     64'(bus.ref_coor_x), rp[0] & MAXV);
        chk({ctx, ".ref_y"},     64'(bus.ref_coor_y), rp[1] & MAXV);
        chk({ctx, ".ref_z"},     64'(bus.ref_coor_z), rp[2] & MAXV);
    endtask

    // Called at edge+1; applies one beat and checks it after the next edge.
    task automatic beat(input bit v, input int c, input int bi, input bit q, input bit r, input string ctx);
        bus.valid     = v;
        bus.code      = 2'(c);
        bus.b         = BW'(bi);
        bus.q_bit     = q;
        bus.r_bit     = r;
        bus.threshold = thr;
        model_step(v, c, bi, q, r);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic junk(input string ctx);
        int kind;
        kind = $urandom_range(0, 3);
        case (kind)
            0:       beat(1'b0, 1, 1, 1'($urandom), 1'($urandom), ctx);
            1:       beat(1'b1, 0, $urandom_range(1, B), 1'($urandom), 1'($urandom), ctx);
            2:       beat(1'b1, $urandom_range(1, 3), 0, 1'($urandom), 1'($urandom), ctx);
            default: beat(1'b1, $urandom_range(1, 3), $urandom_range(B + 1, (1 << BW) - 1),
                          1'($urandom), 1'($urandom), ctx);
        endcase
    endtask

    task automatic run_beats(input int from, input int to, input bit with_junk, input string ctx);
        int d, bi;
        for (int i = from; i < to; i++) begin
            if (with_junk && $urandom_range(0, 7) == 0) junk(ctx);
            d  = i % 3;
            bi = i / 3 + 1;
            beat(1'b1, d + 1, bi, qs[d][B - bi], rs[d][B - bi], ctx);
        end
    endtask

    initial begin
        bus.valid = 0; bus.code = 0; bus.b = '0; bus.q_bit = 0; bus.r_bit = 0;
        bus.threshold = '0;
        thr = 32'd13;
        model_reset();

        // Reset held low for three cycles, then idle beats.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) beat(1'b0, (i % 3) + 1, i + 1, 1'b1, 1'b0, "idle");

        // Near-equal coordinates: exact distance 12, threshold 13 -> done.
        for (int d = 0; d < 3; d++) begin qs[d] = 32'h0000_FFFD; rs[d] = 32'h0000_FFFF; end
        thr = 32'd13;
        run_beats(0, 96, 1'b0, "s2");
        chk("s2.partial12", 64'(bus.partial_distance_output), 64'd12);
        chk("s2.done",      64'(bus.done), 64'd1);
        chk("s2.term",      64'(bus.terminate), 64'd0);
        chk("s2.ref_x",     64'(bus.ref_coor_x), 64'h0000_FFFF);
        chk("s2.ref_z",     64'(bus.ref_coor_z), 64'h0000_FFFF);

        // Restart from done, then the large-x stream that rejects on beat 3.
        qs[0] = 32'h8000_0000; rs[0] = 32'h0;
        qs[1] = 32'h0; rs[1] = 32'h0; qs[2] = 32'h0; rs[2] = 32'h0;
        run_beats(0, 1, 1'b0, "s5");
        chk("s5.done",    64'(bus.done), 64'd0);
        chk("s5.partial", 64'(bus.partial_distance_output), 64'd0);
        chk("s5.ref_x",   64'(bus.ref_coor_x), 64'd0);
        run_beats(1, 4, 1'b0, "s4");
        chk("s4.partial_sat", 64'(bus.partial_distance_output), 64'hFFFF_FFFF);
        chk("s4.term",        64'(bus.terminate), 64'd1);
        run_beats(4, 96, 1'b0, "s4");
        chk("s4.hold_sat",  64'(bus.partial_distance_output), 64'hFFFF_FFFF);
        chk("s4.hold_term", 64'(bus.terminate), 64'd1);
        chk("s4.no_done",   64'(bus.done), 64'd0);

        // Same near-equal stream with threshold 12: reject on the very last beat.
        for (int d = 0; d < 3; d++) begin qs[d] = 32'h0000_FFFD; rs[d] = 32'h0000_FFFF; end
        thr = 32'd12;
        run_beats(0, 94, 1'b0, "s3");
        chk("s3.partial4", 64'(bus.partial_distance_output), 64'd4);
        run_beats(94, 95, 1'b0, "s3");
        chk("s3.partial8", 64'(bus.partial_distance_output), 64'd8);
        run_beats(95, 96, 1'b0, "s3");
        chk("s3.partial12", 64'(bus.partial_distance_output), 64'd12);
        chk("s3.term",      64'(bus.terminate), 64'd1);
        chk("s3.done",      64'(bus.done), 64'd0);

        // Mid-stream no-op beats, then asynchronous reset between edges.
        for (int d = 0; d < 3; d++) begin qs[d] = $urandom; rs[d] = qs[d] ^ ($urandom & 32'h0000_000F); end
        thr = 32'hFFFF_FFFF;
        run_beats(0, 40, 1'b0, "s6");
        for (int i = 0; i < 4; i++) beat(1'b1, 0, 14, 1'b1, 1'b0, "s6_noop");
        #2;
        rst = 1'b0;
        #1;
        chk("s6.arst_partial", 64'(bus.partial_distance_output), 64'd0);
        chk("s6.arst_ref_x",   64'(bus.ref_coor_x), 64'd0);
        chk("s6.arst_debug",   64'(bus.debug), 64'd0);
        chk("s6.arst_term",    64'(bus.terminate), 64'd0);
        model_reset();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("s6_post");

        // Random streams with interleaved invalid beats.
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 3; d++) begin
                qs[d] = $urandom;
                rs[d] = (k % 2 == 0) ? (qs[d] ^ ($urandom & 32'h0000_03FF)) : $urandom;
            end
            thr = (k % 3 == 0) ? $urandom : ($urandom & 32'h000F_FFFF);
            run_beats(0, 96, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
